// File: rtl/sdram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_cmd_arbiter
//
// Shares the single SDRAM command/address/data bus among the initialisation,
// auto-refresh, burst-write and burst-read sub-controllers.
//   * Until init_end is seen the init sequence is passed straight through.
//   * Afterwards exactly one requester owns the bus at a time.
//   * Auto-refresh wins over data bursts.
//   * Write and read alternate round-robin when both are pending.
//
// Ports
//   sys_clk, rst_n                      clock, async active-low reset
//   init_end, init_cmd/ba/addr          init phase control and bus
//   aref_req, aref_end, aref_cmd/ba/addr refresh request/finish and bus
//   wr_req, wr_end, write_cmd/ba/addr   write burst request/finish and bus
//   wr_sdram_en, wr_sdram_data          write data and its drive enable
//   rd_req, rd_end, read_cmd/ba/addr    read burst request/finish and bus
//   aref_en, wr_en, rd_en               one-hot grants (decoded from state)
//   sdram_cmd/ba/addr                   SDRAM command bus
//   sdram_dq_out, sdram_dq_oe           DQ output data and output enable
// ---------------------------------------------------------------------------
module sdram_cmd_arbiter #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  write_cmd,
    input  logic [1:0]  write_ba,
    input  logic [12:0] write_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  read_cmd,
    input  logic [1:0]  read_ba,
    input  logic [12:0] read_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_wr_q;   // 1: most recent data burst granted was a write
    logic   last_wr_d;

    // State and round-robin history registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Next-state: priority arbitration in ARBIT, hold ownership until own end pulse
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            ST_INIT: begin
                if (init_end) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_ARBIT: begin
                if (aref_req) begin
                    // Refresh does not disturb the write/read alternation
                    state_d = ST_AREF;
                end else if (wr_req && rd_req) begin
                    // Both pending: give the bus to whichever did not go last
                    if (last_wr_q) begin
                        state_d   = ST_READ;
                        last_wr_d = 1'b0;
                    end else begin
                        state_d   = ST_WRITE;
                        last_wr_d = 1'b1;
                    end
                end else if (wr_req) begin
                    state_d   = ST_WRITE;
                    last_wr_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = ST_READ;
                    last_wr_d = 1'b0;
                end else begin
                    state_d = ST_ARBIT;
                end
            end
            ST_AREF: begin
                if (aref_end) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_AREF;
                end
            end
            ST_WRITE: begin
                if (wr_end) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_end) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d   = ST_INIT;
                last_wr_d = 1'b0;
            end
        endcase
    end

    // Grants are pure decodes of the state flop, so they cannot glitch or overlap
    assign aref_en = (state_q == ST_AREF);
    assign wr_en   = (state_q == ST_WRITE);
    assign rd_en   = (state_q == ST_READ);

    // Command bus mux: owner's bus, NOP with all-ones ba/addr when idle
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1fff;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_ARBIT: begin
                sdram_cmd  = CMD_NOP;
                sdram_ba   = 2'b11;
                sdram_addr = 13'h1fff;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = write_cmd;
                sdram_ba   = write_ba;
                sdram_addr = write_addr;
            end
            ST_READ: begin
                sdram_cmd  = read_cmd;
                sdram_ba   = read_ba;
                sdram_addr = read_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_ba   = 2'b11;
                sdram_addr = 13'h1fff;
            end
        endcase
    end

    // DQ is only driven while the write module actually owns the bus
    assign sdram_dq_oe  = wr_sdram_en & (state_q == ST_WRITE);
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : 16'h0000;

endmodule

// File: doc/sdram_cmd_arbiter.md
# sdram_cmd_arbiter

Shares the single SDRAM command/address/data bus among the initialisation, auto-refresh, burst-write and burst-read sub-controllers. It sits between those sub-controllers and the SDRAM pins.
- Before initialisation completes, it passes the init sequence straight through.
- After that, it grants exactly one requester at a time.
- Auto-refresh has the highest priority. Write and read alternate round-robin so neither starves.

## Interface
Parameters:
- CMD_NOP, 4'b0111, command driven when no sub-controller owns the bus ({cs_n,ras_n,cas_n,we_n})

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init_end  in  1  init sequence complete (level, stays high)
- init_cmd / init_ba / init_addr  in  4/2/13  init-phase bus
- aref_req  in  1  refresh request (level, held until granted)
- aref_end  in  1  one-cycle pulse, refresh sequence finished
- aref_cmd / aref_ba / aref_addr  in  4/2/13  refresh-phase bus
- wr_req  in  1  write burst request (level)
- wr_end  in  1  one-cycle pulse, write burst finished
- write_cmd / write_ba / write_addr  in  4/2/13  write-phase bus
- wr_sdram_en  in  1  write module drives DQ this cycle
- wr_sdram_data  in  16  write data
- rd_req  in  1  read burst request (level)
- rd_end  in  1  one-cycle pulse, read burst finished
- read_cmd / read_ba / read_addr  in  4/2/13  read-phase bus
- aref_en / wr_en / rd_en  out  1 each  grant to sub-controller, at most one high
- sdram_cmd / sdram_ba / sdram_addr  out  4/2/13  SDRAM bus
- sdram_dq_out  out  16  DQ output data
- sdram_dq_oe  out  1  DQ output enable (pad tri-state done at top level)

## Operation
- State register (registered): INIT, ARBIT, AREF, WRITE, READ. A one-bit register last_wr records the most recently granted data burst.
- INIT
  - sdram_cmd/ba/addr = init_* (combinational).
  - init_end=1 -> ARBIT.
- ARBIT
  - Bus = CMD_NOP, ba=2'b11, addr=13'h1fff.
  - Priority: aref_req -> AREF. Else wr_req & rd_req: go READ if last_wr=1, else WRITE. Else wr_req -> WRITE. Else rd_req -> READ. Else stay.
- AREF, WRITE, READ
  - Bus muxes the corresponding *_cmd/_ba/_addr.
  - The matching grant is high for the whole state.
  - On the matching *_end -> ARBIT.
  - *_end pulses from non-granted modules are ignored.
- Grant updates:
  - Entering WRITE sets last_wr=1.
  - Entering READ clears last_wr=0.
  - AREF does not change last_wr.
- Preemption: none. A pending aref_req waits until the current burst's *_end. Sub-controllers must bound burst length to meet the refresh interval.
- DQ: sdram_dq_oe = wr_sdram_en & (state==WRITE). sdram_dq_out = wr_sdram_data when oe=1, else 16'h0.
- Grants are decoded from the state register: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). They are glitch-free and mutually exclusive.
- Reset mid-operation: on rst_n low, all registers return to reset values immediately, whatever the state.

## Timing
- Reset values:
  - state=INIT, last_wr=0.
  - aref_en=wr_en=rd_en=0, sdram_dq_oe=0, sdram_dq_out=0.
  - sdram_cmd/ba/addr follow init_* (combinational).
- Cycle N init_end sampled high -> state ARBIT at N+1.
- ARBIT sampling request at cycle N -> state and grant high from N+1.
- *_end sampled at N -> grant low and state ARBIT at N+1. The next grant is at N+2 at the earliest.
- Minimum one NOP (ARBIT) cycle between consecutive grants.
- Simultaneous aref_req, wr_req and rd_req in ARBIT -> AREF. After aref_end, the next grant follows the round-robin rule.
- *_end arriving in the same cycle as the grant edge is honoured only if state already matches.

## Test plan
- Reset then init: hold init_end=0 with init_cmd=4'b0010 -> sdram_cmd=0010, all grants 0. Raise init_end at cycle N -> sdram_cmd=0111 at N+1.
- Single write: wr_req=1 in ARBIT at N -> wr_en=1 at N+1 and sdram_cmd=write_cmd. wr_sdram_en=1 with data 16'h00AB -> dq_oe=1, dq_out=00AB. wr_end at M -> wr_en=0 and cmd=0111 at M+1.
- Round-robin: wr_req and rd_req held high with 4-cycle bursts -> grant order WRITE, READ, WRITE, READ, each separated by exactly one ARBIT cycle.
- Refresh priority: aref_req raised mid-write -> wr_en stays until wr_end, then one ARBIT cycle, then aref_en=1 even though rd_req=1. After aref_end, READ is granted.
- Stray end pulses and illegal DQ: rd_end pulses during WRITE -> no state change. wr_sdram_en=1 during READ -> dq_oe stays 0.
- Reset mid-burst: drop rst_n during READ -> rd_en=0 and state=INIT immediately. After release, sdram_cmd follows init_cmd until init_end.
